bbox_overlay_tracker: RTL and testbench
=======================================

Name: bbox_overlay_tracker

Overview:
- Sits directly downstream of the bounding-box stage.
- Takes each detected box (centre plus right/bottom edge), reconstructs the full rectangle and smooths it across frames.
- Draws a THICK-pixel outline in OVERLAY_COLOR onto the pixel stream headed to the display.
- Keeps drawing the last box for a bounded number of frames when detection drops out, then blanks the overlay.

Parameters:
- H_PIXELS, 960, active width; right edge clamps to H_PIXELS-1
- V_PIXELS, 640, active height; bottom edge clamps to V_PIXELS-1
- THICK, 2, outline thickness in pixels (1..8)
- SHIFT, 1, smoothing shift; per-frame update is cur += (new-cur)>>>SHIFT; SHIFT=0 means no smoothing
- TIMEOUT_FRAMES, 30, consecutive frames without a box before the overlay drops (>=1)
- OVERLAY_COLOR, 16'hF800, RGB565 outline colour

Ports:
- clk_in  input  1  pixel clock
- rst_n_in  input  1  reset
- hcount_in  input  11  current pixel x
- vcount_in  input  10  current pixel y
- pixel_in  input  16  RGB565 pixel
- pixel_valid_in  input  1  pixel_in qualifier
- box_x_in  input  11  box centre x
- box_y_in  input  10  box centre y
- box_r_in  input  11  right edge x (absolute)
- box_b_in  input  10  bottom edge y (absolute)
- box_valid_in  input  1  one-cycle pulse; box fields valid
- enable_in  input  1  overlay enable; 0 = pass-through, tracking continues
- pixel_out  output  16  pixel with overlay
- pixel_valid_out  output  1  pixel_valid_in delayed 1 cycle
- box_active_out  output  1  high in TRACK or COAST
- left_out  output  11  committed left edge
- top_out  output  10  committed top edge
- right_out  output  11  committed right edge
- bottom_out  output  10  committed bottom edge

Behaviour:
- Clock and reset: one clock, clk_in; reset rst_n_in is synchronous and active-low.
- Reset values: every output 0; state IDLE; pending=0; miss_cnt=0; frame-start flag clear.
- Reset asserted mid-frame takes effect on the next edge; no partial outline is drawn afterwards.
- Capture, on box_valid_in:
  - R = min(box_r_in, H_PIXELS-1); if R < box_x_in then R = box_x_in.
  - L = (2*box_x_in > R) ? 2*box_x_in - R : 0. Use a 12-bit intermediate.
  - T and B are computed the same way from box_y_in and box_b_in.
  - Result goes into the pending registers and sets pending=1. A newer pulse overwrites an uncommitted one.
- Frame start:
  - Defined as the first cycle with hcount_in==0 && vcount_in==0.
  - A registered copy of the condition makes a held (0,0) count once.
- Commit, at frame start only:
  - State machine: IDLE, TRACK, COAST.
  - pending=1 and state IDLE: load L/T/R/B directly, go to TRACK.
  - pending=1 and state TRACK/COAST: each edge e <= e + ((p-e)>>>SHIFT), arithmetic signed 13-bit then truncated; go to TRACK; miss_cnt <= 0; clear pending.
  - pending=0 and state TRACK/COAST: miss_cnt++. When miss_cnt+1 == TIMEOUT_FRAMES, go to IDLE and clear miss_cnt; otherwise go to COAST.
  - pending=0 and state IDLE: no change.
- box_valid_in coinciding with frame start: commit uses the prior pending contents; the new box lands in pending for the next frame.
- left/top/right/bottom_out change only at commit. They hold their values in COAST and in IDLE.
- Draw, 1-cycle latency:
  - hit = active && enable_in && L<=h<=R && T<=v<=B && (h-L<THICK || R-h<THICK || v-T<THICK || B-v<THICK).
  - pixel_out <= hit ? OVERLAY_COLOR : pixel_in.
  - hcount/vcount are registered with pixel_in so all three align.
  - pixel_valid_out <= pixel_valid_in. Invalid pixels pass through unmodified.

Test Plan:
- Basic draw: reset; box (x=100, y=80, r=130, b=100) pulse; frame start → L=70, T=60, R=130, B=100, box_active_out=1. Next frame: pixels (70,80), (71,80), (100,60), (130,100) = F800; (72,80) and (100,80) = pixel_in; all one cycle after input.
- Smoothing: after the basic-draw box, box (x=200, y=80, r=230, b=100) then frame start → L=120, R=180, T=60, B=100.
- Clamp: box (x=10, y=5, r=40, b=700) → L=0, R=40, B=639, T=0 (2*5=10 < 639).
- Timeout with TIMEOUT_FRAMES=3: box then three box-less frame starts → COAST, COAST, IDLE. box_active_out falls at the third frame start; no F800 pixels afterwards.
- Simultaneous/held frame start: box_valid_in on the (0,0) cycle with pending=0, and hcount/vcount held at (0,0) for 4 cycles → counts as a miss (COAST); box commits at the following frame start.
- Enable and reset: enable_in=0 → pixel_out==pixel_in while box_active_out stays 1. rst_n_in=0 mid-frame → next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/bbox_overlay_tracker.sv
// Rebuilds detected boxes from centre + right/bottom edge, smooths them per frame,
// and draws a THICK-pixel outline over the display pixel stream with a coast-out timeout.
module bbox_overlay_tracker #(
    parameter int          H_PIXELS       = 960,
    parameter int          V_PIXELS       = 640,
    parameter int          THICK          = 2,
    parameter int          SHIFT          = 1,
    parameter int          TIMEOUT_FRAMES = 30,
    parameter logic [15:0] OVERLAY_COLOR  = 16'hF800
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [15:0] pixel_in,
    input  logic        pixel_valid_in,
    input  logic [10:0] box_x_in,
    input  logic [9:0]  box_y_in,
    input  logic [10:0] box_r_in,
    input  logic [9:0]  box_b_in,
    input  logic        box_valid_in,
    input  logic        enable_in,
    output logic [15:0] pixel_out,
    output logic        pixel_valid_out,
    output logic        box_active_out,
    output logic [10:0] left_out,
    output logic [9:0]  top_out,
    output logic [10:0] right_out,
    output logic [9:0]  bottom_out
);

    typedef struct packed {
        logic [10:0] l;
        logic [9:0]  t;
        logic [10:0] r;
        logic [9:0]  b;
    } box_t;

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_TRACK = 2'd1;
    localparam logic [1:0]  S_COAST = 2'd2;
    localparam int          MCW     = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [10:0] TH_H    = 11'(THICK);
    localparam logic [9:0]  TH_V    = 10'(THICK);

    logic [1:0]     state;
    logic [MCW-1:0] miss_cnt;
    logic           pending;
    logic           fs_q;
    logic           vld_pipe;
    box_t           pend, edges, cap, smoothed;
    logic [10:0]    r_c;
    logic [9:0]     b_c;
    logic [11:0]    x2, y2;
    logic           frame_start, in_box, on_edge, hit;

    // Signed 13-bit step toward the new edge, then truncated back to edge width.
    function automatic logic [12:0] smooth(input logic [12:0] e, input logic [12:0] p);
        logic signed [12:0] d;
        d = $signed(p) - $signed(e);
        return e + $unsigned(d >>> SHIFT);
    endfunction

    // Mirror the right/bottom edge about the centre to recover left/top.
    always_comb begin
        r_c = (box_r_in > 11'(H_PIXELS - 1)) ? 11'(H_PIXELS - 1) : box_r_in;
        if (r_c < box_x_in) r_c = box_x_in;
        b_c = (box_b_in > 10'(V_PIXELS - 1)) ? 10'(V_PIXELS - 1) : box_b_in;
        if (b_c < box_y_in) b_c = box_y_in;
        x2    = {box_x_in, 1'b0};
        y2    = {1'b0, box_y_in, 1'b0};
        cap   = '0;
        cap.r = r_c;
        cap.b = b_c;
        cap.l = (x2 > {1'b0, r_c})  ? 11'(x2 - {1'b0, r_c})  : '0;
        cap.t = (y2 > {2'b0, b_c})  ? 10'(y2 - {2'b0, b_c})  : '0;
    end

    always_comb begin
        smoothed   = '0;
        smoothed.l = 11'(smooth({2'b0, edges.l}, {2'b0, pend.l}));
        smoothed.t = 10'(smooth({3'b0, edges.t}, {3'b0, pend.t}));
        smoothed.r = 11'(smooth({2'b0, edges.r}, {2'b0, pend.r}));
        smoothed.b = 10'(smooth({3'b0, edges.b}, {3'b0, pend.b}));
    end

    // A (0,0) held for several cycles still yields a single frame start.
    assign frame_start = (hcount_in == '0) && (vcount_in == '0) && !fs_q;

    always_comb begin
        in_box  = (hcount_in >= edges.l) && (hcount_in <= edges.r) &&
                  (vcount_in >= edges.t) && (vcount_in <= edges.b);
        on_edge = ((hcount_in - edges.l) < TH_H) || ((edges.r - hcount_in) < TH_H) ||
                  ((vcount_in - edges.t) < TH_V) || ((edges.b - vcount_in) < TH_V);
        hit     = (state != S_IDLE) && enable_in && pixel_valid_in && in_box && on_edge;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state     <= S_IDLE;
            miss_cnt  <= '0;
            pending   <= 1'b0;
            fs_q      <= 1'b0;
            vld_pipe  <= 1'b0;
            pend      <= '0;
            edges     <= '0;
            pixel_out <= '0;
        end else begin
            fs_q      <= (hcount_in == '0) && (vcount_in == '0);
            vld_pipe  <= pixel_valid_in;
            pixel_out <= hit ? OVERLAY_COLOR : pixel_in;
            if (frame_start) begin
                if (pending) begin
                    edges    <= (state == S_IDLE) ? pend : smoothed;
                    state    <= S_TRACK;
                    miss_cnt <= '0;
                    pending  <= 1'b0;
                end else if (state != S_IDLE) begin
                    if (32'(miss_cnt) + 1 == TIMEOUT_FRAMES) begin
                        state    <= S_IDLE;
                        miss_cnt <= '0;
                    end else begin
                        state    <= S_COAST;
                        miss_cnt <= miss_cnt + 1'b1;
                    end
                end
            end
            // Written after the commit so a coincident box survives into the next frame.
            if (box_valid_in) begin
                pend    <= cap;
                pending <= 1'b1;
            end
        end
    end

    assign pixel_valid_out = vld_pipe;
    assign box_active_out  = (state != S_IDLE);
    assign left_out        = edges.l;
    assign top_out         = edges.t;
    assign right_out       = edges.r;
    assign bottom_out      = edges.b;

endmodule

// File: tb/tb_bbox_overlay_tracker.sv
// Directed bench for bbox_overlay_tracker: box outputs checked inline,
// overlay pixels checked by a scoreboard monitor on pixel_valid_out.
module tb_bbox_overlay_tracker;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [15:0] pixel_in;
    logic        pixel_valid_in;
    logic [10:0] box_x_in, box_r_in;
    logic [9:0]  box_y_in, box_b_in;
    logic        box_valid_in;
    logic        enable_in;
    logic [15:0] pixel_out;
    logic        pixel_valid_out;
    logic        box_active_out;
    logic [10:0] left_out, right_out;
    logic [9:0]  top_out, bottom_out;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    localparam logic [15:0] RED = 16'hF800;

    bbox_overlay_tracker #(.TIMEOUT_FRAMES(3)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .pixel_in(pixel_in), .pixel_valid_in(pixel_valid_in),
        .box_x_in(box_x_in), .box_y_in(box_y_in),
        .box_r_in(box_r_in), .box_b_in(box_b_in),
        .box_valid_in(box_valid_in), .enable_in(enable_in),
        .pixel_out(pixel_out), .pixel_valid_out(pixel_valid_out),
        .box_active_out(box_active_out),
        .left_out(left_out), .top_out(top_out),
        .right_out(right_out), .bottom_out(bottom_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every valid output pixel must match the next scoreboard entry.
    initial begin
        forever begin
            @(negedge clk_in);
            if (pixel_valid_out) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got 0x%0h with nothing expected", pixel_out);
                end else begin
                    chk("pixel_out", {16'b0, pixel_out}, {16'b0, sb.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic park();
        hcount_in      = 11'd500;
        vcount_in      = 10'd500;
        pixel_valid_in = 1'b0;
        box_valid_in   = 1'b0;
    endtask

    task automatic send_box(input int x, input int y, input int r, input int b);
        box_x_in     = 11'(x);
        box_y_in     = 10'(y);
        box_r_in     = 11'(r);
        box_b_in     = 10'(b);
        box_valid_in = 1'b1;
        @(negedge clk_in);
        box_valid_in = 1'b0;
    endtask

    task automatic frame_start();
        hcount_in = '0;
        vcount_in = '0;
        @(negedge clk_in);
        park();
        @(negedge clk_in);
    endtask

    task automatic pix(input int h, input int v, input logic [15:0] p, input logic [15:0] exp);
        hcount_in      = 11'(h);
        vcount_in      = 10'(v);
        pixel_in       = p;
        pixel_valid_in = 1'b1;
        sb.push_back(exp);
        @(negedge clk_in);
        pixel_valid_in = 1'b0;
    endtask

    task automatic check_box(input string tag, input int l, input int t, input int r,
                             input int b, input logic act);
        chk({tag, "_left"},   32'(left_out),   32'(l));
        chk({tag, "_top"},    32'(top_out),    32'(t));
        chk({tag, "_right"},  32'(right_out),  32'(r));
        chk({tag, "_bottom"}, 32'(bottom_out), 32'(b));
        chk({tag, "_active"}, 32'(box_active_out), 32'(act));
    endtask

    initial begin
        rst_n_in  = 1'b0;
        enable_in = 1'b1;
        pixel_in  = '0;
        box_x_in  = '0; box_y_in = '0; box_r_in = '0; box_b_in = '0;
        park();
        repeat (3) @(negedge clk_in);
        check_box("reset", 0, 0, 0, 0, 1'b0);
        chk("reset_pixel_out", 32'(pixel_out), 0);
        chk("reset_pixel_valid_out", 32'(pixel_valid_out), 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Basic capture and draw
        send_box(100, 80, 130, 100);
        check_box("pre_commit", 0, 0, 0, 0, 1'b0);
        frame_start();
        check_box("basic", 70, 60, 130, 100, 1'b1);
        pix(70, 80, 16'h1234, RED);
        pix(71, 80, 16'h1234, RED);
        pix(100, 60, 16'h2345, RED);
        pix(130, 100, 16'h3456, RED);
        pix(72, 80, 16'h4567, 16'h4567);
        pix(100, 80, 16'h5678, 16'h5678);
        pix(69, 80, 16'h6789, 16'h6789);
        pix(131, 100, 16'h789A, 16'h789A);

        // Smoothing toward a shifted box
        send_box(200, 80, 230, 100);
        frame_start();
        check_box("smooth", 120, 60, 180, 100, 1'b1);
        pix(120, 60, 16'h0F0F, RED);
        pix(119, 80, 16'h0E0E, 16'h0E0E);

        // Overlay disabled: pass-through, tracking stays up
        enable_in = 1'b0;
        pix(120, 80, 16'h0AAA, 16'h0AAA);
        chk("disable_active", 32'(box_active_out), 1);
        enable_in = 1'b1;

        // Timeout after three box-less frames
        frame_start();
        check_box("coast1", 120, 60, 180, 100, 1'b1);
        pix(121, 80, 16'h0BBB, RED);
        frame_start();
        check_box("coast2", 120, 60, 180, 100, 1'b1);
        frame_start();
        check_box("timeout", 120, 60, 180, 100, 1'b0);
        pix(120, 80, 16'h0CCC, 16'h0CCC);
        pix(180, 100, 16'h0DDD, 16'h0DDD);

        // Clamp from IDLE loads directly
        send_box(10, 5, 40, 700);
        frame_start();
        check_box("clamp", 0, 0, 40, 639, 1'b1);
        pix(0, 639, 16'h1111, RED);
        pix(20, 300, 16'h2222, 16'h2222);

        // Box on a held (0,0): one miss now, commit at the next frame start
        hcount_in = '0;
        vcount_in = '0;
        box_x_in = 11'd300; box_y_in = 10'd200; box_r_in = 11'd320; box_b_in = 10'd220;
        box_valid_in = 1'b1;
        @(negedge clk_in);
        box_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        park();
        @(negedge clk_in);
        check_box("held_miss", 0, 0, 40, 639, 1'b1);
        frame_start();
        check_box("held_commit", 140, 90, 180, 429, 1'b1);
        pix(140, 90, 16'h3333, RED);

        // Reset mid-frame on a pixel that would hit the outline
        hcount_in      = 11'd140;
        vcount_in      = 10'd90;
        pixel_in       = 16'h4444;
        pixel_valid_in = 1'b1;
        rst_n_in       = 1'b0;
        @(negedge clk_in);
        pixel_valid_in = 1'b0;
        check_box("midreset", 0, 0, 0, 0, 1'b0);
        chk("midreset_pixel_out", 32'(pixel_out), 0);
        chk("midreset_pixel_valid_out", 32'(pixel_valid_out), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        pix(140, 90, 16'h5555, 16'h5555);
        pix(0, 0, 16'h6666, 16'h6666);

        park();
        repeat (4) @(negedge clk_in);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
